// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the instruction stream encoder: request kinds,
// opcodes, the canonical NOP and small helpers.
package riscv_pkg;

    typedef enum logic [2:0] {
        KindAluR     = 3'd0,
        KindAluI     = 3'd1,
        KindBranchEq = 3'd2,
        KindJump     = 3'd3,
        KindLoad     = 3'd4,
        KindStore    = 3'd5
    } req_kind_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StFull
    } enc_state_e;

    localparam logic [6:0]  OpcAluR   = 7'b0110011;
    localparam logic [6:0]  OpcAluI   = 7'b0010011;
    localparam logic [6:0]  OpcBranch = 7'b1100011;
    localparam logic [6:0]  OpcJal    = 7'b1101111;
    localparam logic [6:0]  OpcLoad   = 7'b0000011;
    localparam logic [6:0]  OpcStore  = 7'b0100011;
    localparam logic [31:0] Nop       = 32'h0000_0013;

    function automatic logic kind_is_legal(logic [2:0] kind);
        return kind <= 3'd5;
    endfunction

    // True when imm, read as signed, fits a two's-complement field of 'bits' bits.
    function automatic logic imm_fits(logic [31:0] imm, int unsigned bits);
        int lim;
        lim = 1 << (bits - 1);
        return ($signed(imm) >= -lim) && ($signed(imm) < lim);
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request bus into the encoder: valid/ready handshake plus instruction fields.
interface instr_stream_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    modport master (
        output req_valid, req_kind, rd, rs1, rs2, funct3, funct7, imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_kind, rd, rs1, rs2, funct3, funct7, imm,
        output req_ready
    );
endinterface

// File: rtl/instr_format_pack.sv
// Combinational RV32 field packer. With ENCODER_RANGE_CHECK_EN defined, an
// out-of-range immediate raises range_err_o and the word becomes a NOP.
module instr_format_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o
);

    logic [31:0] raw;

    always_comb begin
        raw = Nop;
        case (kind_i)
            KindAluR:     raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OpcAluR};
            KindAluI:     raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpcAluI};
            KindLoad:     raw = {imm_i[11:0], rs1_i, 3'b010, rd_i, OpcLoad};
            KindStore:    raw = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OpcStore};
            KindBranchEq: raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                                 imm_i[4:1], imm_i[11], OpcBranch};
            KindJump:     raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OpcJal};
            default:      raw = Nop;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic oor;

    always_comb begin
        oor = 1'b0;
        case (kind_i)
            KindAluI, KindLoad, KindStore: oor = !imm_fits(imm_i, 12);
            KindBranchEq:                  oor = !imm_fits(imm_i, 13) || imm_i[0];
            KindJump:                      oor = !imm_fits(imm_i, 21) || imm_i[0];
            default:                       oor = 1'b0;
        endcase
    end

    assign word_o      = oor ? Nop : raw;
    assign range_err_o = oor;
`else
    // Upper immediate bits only matter to the range check.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_i[31:21];
    assign word_o        = raw;
    assign range_err_o   = 1'b0;
`endif

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams encoded RV32 instructions into instruction memory, one word per two
// cycles. Optional immediate range checking via ENCODER_RANGE_CHECK_EN.
module instr_stream_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start,
    input  logic [IMEM_AW-1:0]   base_addr,
    input  logic                 stop,
    instr_stream_encoder_if.slave req,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 full,
    output logic                 done,
    output logic                 err_illegal,
    output logic                 err_range,
    output logic [IMEM_AW:0]     count
);

    enc_state_e       state_q;
    logic [IMEM_AW-1:0] ptr_q;
    logic [IMEM_AW:0] count_q;
    logic [31:0]      wdata_q;
    logic             imem_we_q, req_ready_q, full_q, done_q;
    logic             err_illegal_q, err_range_q, stop_pend_q;
    logic [31:0]      pack_word;
    logic             pack_range;
    logic             hs;

    instr_format_pack u_pack (
        .kind_i      (req.req_kind),
        .rd_i        (req.rd),
        .rs1_i       (req.rs1),
        .rs2_i       (req.rs2),
        .funct3_i    (req.funct3),
        .funct7_i    (req.funct7),
        .imm_i       (req.imm),
        .word_o      (pack_word),
        .range_err_o (pack_range)
    );

    assign hs = req.req_valid && req_ready_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            count_q       <= '0;
            wdata_q       <= '0;
            imem_we_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            full_q        <= 1'b0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_range_q   <= 1'b0;
            stop_pend_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ptr_q         <= base_addr;
                        count_q       <= '0;
                        err_illegal_q <= 1'b0;
                        err_range_q   <= 1'b0;
                        full_q        <= 1'b0;
                        stop_pend_q   <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= StAccept;
                    end
                end
                StAccept: begin
                    if (hs && !kind_is_legal(req.req_kind)) begin
                        err_illegal_q <= 1'b1;
                    end
                    if (hs && kind_is_legal(req.req_kind)) begin
                        wdata_q     <= pack_word;
                        err_range_q <= err_range_q | pack_range;
                        imem_we_q   <= 1'b1;
                        req_ready_q <= 1'b0;
                        stop_pend_q <= stop;
                        state_q     <= StWrite;
                    end else if (stop) begin
                        req_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StWrite: begin
                    imem_we_q <= 1'b0;
                    count_q   <= count_q + (IMEM_AW + 1)'(1);
                    // Pointer saturates at the top address; FULL is terminal until stop.
                    if (ptr_q != {IMEM_AW{1'b1}}) begin
                        ptr_q <= ptr_q + IMEM_AW'(1);
                    end
                    if (stop_pend_q || stop) begin
                        stop_pend_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end else if (ptr_q == {IMEM_AW{1'b1}}) begin
                        full_q  <= 1'b1;
                        state_q <= StFull;
                    end else begin
                        req_ready_q <= 1'b1;
                        state_q     <= StAccept;
                    end
                end
                StFull: begin
                    if (stop) begin
                        full_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req.req_ready = req_ready_q;
    assign imem_we       = imem_we_q;
    assign imem_addr     = ptr_q;
    assign imem_wdata    = wdata_q;
    assign full          = full_q;
    assign done          = done_q;
    assign err_illegal   = err_illegal_q;
    assign err_range     = err_range_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder; honours ENCODER_RANGE_CHECK_EN.
module tb_instr_stream_encoder;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        imem_we, full, done, err_illegal, err_range;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;

    logic        start2 = 1'b0, stop2 = 1'b0;
    logic [1:0]  base2 = '0;
    logic        we2, full2, done2, ill2, rng2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    instr_stream_encoder_if bus ();
    instr_stream_encoder_if bus2 ();

    instr_stream_encoder #(.IMEM_AW(10)) dut (
        .clk(clk), .arst(arst), .start(start), .base_addr(base_addr), .stop(stop),
        .req(bus.slave), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .full(full), .done(done), .err_illegal(err_illegal), .err_range(err_range),
        .count(count)
    );

    instr_stream_encoder #(.IMEM_AW(2)) dut2 (
        .clk(clk), .arst(arst), .start(start2), .base_addr(base2), .stop(stop2),
        .req(bus2.slave), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .full(full2), .done(done2), .err_illegal(ill2), .err_range(rng2), .count(count2)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0;
    wr_t         exp_q[$], exp_q2[$];
    int          wr_cyc[$];
    logic [31:0] exp_ptr = 0;
    int          exp_count = 0;
    bit          exp_err_illegal = 0, exp_err_range = 0;

`ifdef ENCODER_RANGE_CHECK_EN
    localparam logic [31:0] RangeWord = 32'h0000_0013;
    localparam logic        RangeFlag = 1'b1;
`else
    localparam logic [31:0] RangeWord = 32'h8000_0093;
    localparam logic        RangeFlag = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [31:0] model_word(input int kind, input logic [31:0] rd,
            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
            input logic [31:0] f7, input logic [31:0] u, output bit oor);
        int si;
        si  = $signed(u);
        oor = 0;
        case (kind)
            0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            1: begin
                oor = (si < -2048) || (si > 2047);
                return ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            2: begin
                oor = (si < -4096) || (si > 4095) || u[0];
                return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20) |
                       (rs1 << 15) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) |
                       32'h63;
            end
            3: begin
                oor = (si < -1048576) || (si > 1048575) || u[0];
                return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                       (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (rd << 7) |
                       32'h6f;
            end
            4: begin
                oor = (si < -2048) || (si > 2047);
                return ((u & 32'hfff) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            end
            5: begin
                oor = (si < -2048) || (si > 2047);
                return (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
                       ((u & 32'h1f) << 7) | 32'h23;
            end
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("write_without_request", 64'(imem_we), 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("imem_addr", 64'(imem_addr), 64'(e.addr));
                chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
            end
        end
        if (we2 === 1'b1) begin
            if (exp_q2.size() == 0) chk("dut2_write_without_request", 64'(we2), 64'd0);
            else begin
                e = exp_q2.pop_front();
                chk("dut2_imem_addr", 64'(addr2), 64'(e.addr));
                chk("dut2_imem_wdata", 64'(wdata2), 64'(e.data));
            end
        end
    end

    task automatic start_stream(input logic [9:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp_ptr = 32'(b);
        exp_count = 0;
        exp_err_illegal = 0;
        exp_err_range = 0;
    endtask

    task automatic send(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
            input logic [31:0] imm, input bit with_stop, input bit track);
        logic [31:0] w;
        bit          oor;
        int          n;
        w = model_word(kind, 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm, oor);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind  = 3'(kind);
        bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        stop = with_stop;
        if (track) begin
            if (kind <= 5) begin
`ifdef ENCODER_RANGE_CHECK_EN
                if (oor) begin
                    w = 32'h13;
                    exp_err_range = 1;
                end
`endif
                exp_q.push_back({exp_ptr, w});
                exp_ptr++;
                exp_count++;
            end else exp_err_illegal = 1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic stop_stream();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("done_after_stop", 64'(done), 64'd1);
        chk("ready_idle_after_stop", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] imm;
        int          k;
        bus.req_valid = 1'b0; bus.req_kind = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        bus2.req_valid = 1'b0; bus2.req_kind = '0; bus2.rd = '0; bus2.rs1 = '0; bus2.rs2 = '0;
        bus2.funct3 = '0; bus2.funct7 = '0; bus2.imm = '0;

        @(posedge clk); #1;
        chk("rst_imem_we", 64'(imem_we), 0);
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        chk("rst_flags", {full, done, err_illegal, err_range}, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_wdata", 64'(imem_wdata), 0);
        arst = 1'b0;

        // Single ALU_I write at base 0.
        start_stream(10'd0);
        chk("ready_in_accept", 64'(bus.req_ready), 1);
        send(1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 1);
        chk("alu_i_word", 64'(imem_wdata), 64'h0050_0093);
        chk("alu_i_we", 64'(imem_we), 1);
        @(posedge clk); #1;
        chk("count_one", 64'(count), 1);

        // Start outside IDLE must be ignored; next writes continue at address 1.
        @(negedge clk); start = 1'b1; base_addr = 10'd100;
        @(posedge clk); #1; start = 1'b0;
        wr_cyc.delete();
        send(0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 1);
        chk("alu_r_word", 64'(imem_wdata), 64'h0020_81B3);
        send(2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 0, 1);
        chk("beq_word", 64'(imem_wdata), 64'h0020_8463);
        send(3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 0, 1);
        chk("jal_word", 64'(imem_wdata), 64'h0100_00EF);
        @(posedge clk); #1;
        chk("trio_writes", 64'(wr_cyc.size()), 3);
        if (wr_cyc.size() == 3) begin
            chk("write_gap_1", 64'(wr_cyc[1] - wr_cyc[0]), 2);
            chk("write_gap_2", 64'(wr_cyc[2] - wr_cyc[1]), 2);
        end
        chk("count_four", 64'(count), 4);

        // Immediate just out of 12-bit range.
        send(1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 1);
        chk("range_word", 64'(imem_wdata), 64'(RangeWord));
        chk("range_flag", 64'(err_range), 64'(RangeFlag));
        @(posedge clk); #1;

        // Stop coincident with a handshake.
        send(4, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1, 1);
        chk("stop_hs_we", 64'(imem_we), 1);
        chk("stop_hs_done_early", 64'(done), 0);
        @(posedge clk); #1;
        chk("stop_hs_done", 64'(done), 1);
        chk("stop_hs_idle", 64'(bus.req_ready), 0);
        @(posedge clk); #1;
        chk("stop_hs_done_clear", 64'(done), 0);

        // Illegal kind, then stop raised during WRITE.
        start_stream(10'd20);
        send(7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 0, 1);
        chk("illegal_flag", 64'(err_illegal), 1);
        chk("illegal_stays_accept", 64'(bus.req_ready), 1);
        chk("illegal_no_we", 64'(imem_we), 0);
        send(5, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 32'd100, 0, 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("stop_in_write_done", 64'(done), 1);
        chk("illegal_sticky", 64'(err_illegal), 1);
        chk("count_after_stop", 64'(count), 1);

        // Randomized stream against the reference model.
        start_stream(10'($urandom_range(0, 500)));
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: begin
                    case ($urandom_range(0, 5))
                        0: imm = 32'd2047;
                        1: imm = 32'hFFFF_F800;
                        2: imm = 32'd4094;
                        3: imm = 32'd4096;
                        4: imm = 32'h000F_FFFE;
                        default: imm = 32'hFFF0_0000;
                    endcase
                end
                2: imm = $urandom;
                default: imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & ~32'd1;
            endcase
            send(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 imm, 0, 1);
        end
        @(posedge clk); #1;
        chk("rand_count", 64'(count), 64'(exp_count));
        chk("rand_err_illegal", 64'(err_illegal), 64'(exp_err_illegal));
        chk("rand_err_range", 64'(err_range), 64'(exp_err_range));
        stop_stream();

        // A new start clears the sticky flags and the count.
        start_stream(10'd0);
        chk("restart_flags", {err_illegal, err_range}, 0);
        chk("restart_count", 64'(count), 0);
        stop_stream();

        // Small memory: fills at the last address and stalls further requests.
        @(negedge clk); start2 = 1'b1; base2 = 2'd3;
        @(posedge clk); #1; start2 = 1'b0;
        begin
            bit oor;
            @(negedge clk);
            bus2.req_valid = 1'b1; bus2.req_kind = 3'd1; bus2.rd = 5'd1; bus2.imm = 32'd5;
            exp_q2.push_back({32'd3, model_word(1, 1, 0, 0, 0, 0, 32'd5, oor)});
            @(posedge clk); #1;
            bus2.req_kind = 3'd0; bus2.rd = 5'd3; bus2.rs1 = 5'd1; bus2.rs2 = 5'd2;
            @(posedge clk); #1;
            chk("full_set", 64'(full2), 1);
            chk("full_not_ready", 64'(bus2.req_ready), 0);
            chk("full_count", 64'(count2), 1);
            repeat (4) @(posedge clk);
            #1;
            chk("full_stall_we", 64'(we2), 0);
            chk("full_held", 64'(full2), 1);
            @(negedge clk); stop2 = 1'b1; bus2.req_valid = 1'b0;
            @(posedge clk); #1; stop2 = 1'b0;
            chk("full_stop_done", 64'(done2), 1);
            chk("full_stop_clear", 64'(full2), 0);
            @(posedge clk); #1;
            chk("full_done_pulse", 64'(done2), 0);
        end

        // Asynchronous reset in the middle of WRITE.
        start_stream(10'd7);
        send(1, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd9, 0, 0);
        chk("pre_reset_we", 64'(imem_we), 1);
        #1 arst = 1'b1;
        #1;
        chk("async_rst_we", 64'(imem_we), 0);
        chk("async_rst_count", 64'(count), 0);
        chk("async_rst_ready", 64'(bus.req_ready), 0);
        chk("async_rst_wdata", 64'(imem_wdata), 0);
        chk("async_rst_addr", 64'(imem_addr), 0);
        #1 arst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", {bus.req_ready, full, done}, 0);

        chk("exp_queue_empty", 64'(exp_q.size()), 0);
        chk("exp_queue2_empty", 64'(exp_q2.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_stream_encoder.md
INSTR_STREAM_ENCODER -- requirements
Module: instr_stream_encoder

Interface
REQ-001 SHALL have parameter: IMEM_AW, default 10, instruction-memory word-address width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- arst  in  1  asynchronous, active-high reset.
- start  in  1  begin stream at base_addr.
- base_addr  in  IMEM_AW  first write address.
- stop  in  1  end stream.
- req_valid  in  1  request present.
- req_ready  out  1  request acceptable.
- req_kind  in  3  0 ALU_R, 1 ALU_I, 2 BRANCH_EQ, 3 JUMP, 4 LOAD, 5 STORE, 6-7 illegal.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  used for ALU_R/ALU_I only.
- funct7  in  7  used for ALU_R only.
- imm  in  32  signed immediate or byte offset.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  IMEM_AW  write address.
- imem_wdata  out  32  encoded instruction.
- full  out  1  last address written.
- done  out  1  one-cycle end-of-stream pulse.
- err_illegal  out  1  sticky, illegal kind seen.
- err_range  out  1  sticky, immediate out of range.
- count  out  IMEM_AW+1  words written this stream.

Function
REQ-003 SHALL implement FSM IDLE, ACCEPT, WRITE, FULL; req_ready=1 only in ACCEPT.
REQ-004 IDLE: start loads pointer=base_addr, clears count and both error flags, goes to ACCEPT; start outside IDLE is ignored.
REQ-005 A handshake (req_valid & req_ready) on edge N SHALL register the encoded word; imem_we=1 for exactly one cycle in WRITE (cycle N+1), with imem_addr=pointer; throughput is one word per 2 cycles.
REQ-006 Leaving WRITE, pointer and count SHALL increment; if pointer was 2^IMEM_AW-1 the FSM goes to FULL (full=1, no wrap), else to ACCEPT.
REQ-007 Opcodes SHALL be: ALU_R 0110011, ALU_I 0010011, BRANCH_EQ 1100011, JUMP 1101111, LOAD 0000011, STORE 0100011.
REQ-008 Formats:
- R: funct7|rs2|rs1|funct3|rd|op.
- I: imm[11:0]|rs1|funct3|rd|op; LOAD forces funct3=010.
- S: imm[11:5]|rs2|rs1|010|imm[4:0]|op.
- B: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|op.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-009 Illegal kind SHALL be accepted, set err_illegal and produce no write; the FSM stays in ACCEPT.
REQ-010 stop in ACCEPT or FULL SHALL go to IDLE with done=1 in the next cycle.
REQ-011 stop coincident with a handshake SHALL still write the word, then go to IDLE, with done=1 in the cycle after WRITE.
REQ-012 stop asserted during WRITE SHALL be latched and handled as in REQ-011.

Reset
REQ-013 arst SHALL immediately force IDLE, imem_we=0, req_ready=0, full=0, done=0, both error flags 0, count=0, pointer=0 and imem_wdata=0, including mid-WRITE.

Configuration
REQ-014 With ENCODER_RANGE_CHECK_EN defined, an immediate out of range SHALL set err_range and write NOP 0x00000013 in place of the instruction.
- Ranges: I/LOAD/STORE signed 12-bit; B signed 13-bit and even; J signed 21-bit and even.
REQ-015 Without ENCODER_RANGE_CHECK_EN, immediates SHALL be truncated silently and err_range SHALL be tied 0.

Structure
REQ-016 Shared package riscv_pkg SHALL hold the opcode constants, req_kind encodings and the NOP constant.
REQ-017 The combinational field packer SHALL be sub-module instr_format_pack (kind/fields in, 32-bit word and range flag out).

Verification
REQ-018 Bench SHALL cover these scenarios:
- start base 0; ALU_I rd=1 rs1=0 funct3=0 imm=5 -> single imem_we, addr 0, data 0x00500093; count=1.
- ALU_R rd=3 rs1=1 rs2=2 funct3=0 funct7=0, then BRANCH_EQ rs1=1 rs2=2 imm=8, then JUMP rd=1 imm=16 -> data 0x002081B3, 0x00208463, 0x010000EF at consecutive addresses, writes 2 cycles apart.
- ALU_I rd=1 imm=2048 -> with macro: 0x00000013 and err_range=1; without macro: 0x80000093 and err_range=0.
- IMEM_AW=2, base 3, two back-to-back requests -> first written at address 3; full=1, req_ready=0, second request stalls; stop -> done pulse, IDLE.
- stop coincident with handshake -> word written, done one cycle after WRITE; req_kind=7 -> err_illegal=1, no write.
- arst asserted during WRITE -> imem_we falls without a clock edge; count=0; FSM in IDLE.
